// File: rtl/mem_access_pkg.sv
// Shared types and default sizing for the MEM-stage data-memory access unit.
package mem_access_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts bus wait cycles; expired flags the last cycle allowed before abort.
module mem_wait_timer
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns pipeline memory ops into req/ack bus
// transactions, stalls the pipeline while one is outstanding.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic [ADDR_W-1:0] ALUData_MEM,
  input  logic [DATA_W-1:0] MemWriteData_MEM,
  output logic              stall_MEM,
  output logic [DATA_W-1:0] LoadData_MEM,
  output logic              load_valid,
  output logic              err_misalign,
  output logic              err_conflict,
  output logic              err_timeout,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_t state, state_next;
  logic   conflict, misalign, legal;
  logic   timer_clear, timer_en, expired;

  assign conflict = MemRead_MEM & MemWrite_MEM;
  assign legal    = (MemRead_MEM ^ MemWrite_MEM) & (ALUData_MEM[1:0] == 2'b00);
  // Conflict outranks misalignment, so a misalign needs exactly one request.
  assign misalign = (MemRead_MEM ^ MemWrite_MEM) & (ALUData_MEM[1:0] != 2'b00);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    stall_MEM   = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          state_next  = REQ;
          stall_MEM   = 1'b1;
          timer_clear = 1'b1;
        end
      end
      REQ: begin
        stall_MEM = 1'b1;
        if (bus_ack || expired) begin
          state_next = DONE;
        end else begin
          timer_en = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (rst) begin
      stall_MEM = 1'b0;
    end
  end

  // Bus drive, load capture and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      LoadData_MEM <= '0;
      load_valid   <= 1'b0;
      err_misalign <= 1'b0;
      err_conflict <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      load_valid   <= 1'b0;
      err_misalign <= 1'b0;
      err_conflict <= 1'b0;
      err_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          err_conflict <= conflict;
          err_misalign <= misalign;
          if (legal) begin
            bus_req   <= 1'b1;
            bus_we    <= MemWrite_MEM;
            bus_addr  <= {ALUData_MEM[ADDR_W-1:2], 2'b00};
            bus_wdata <= MemWriteData_MEM;
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
              LoadData_MEM <= bus_rdata;
              load_valid   <= 1'b1;
            end
          end else if (expired) begin
            bus_req     <= 1'b0;
            err_timeout <= 1'b1;
            if (!bus_we) begin
              LoadData_MEM <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
